// File: rtl/bitcoin_pkg.sv
// bitcoin_pkg: shared types, defaults and host state encoding for the bitcoin hash host
package bitcoin_pkg;
  localparam int NUM_NONCES_DEF = 16;
  localparam int NUM_WORDS_DEF = 20;
  typedef logic [31:0] word_t;
  typedef logic [15:0] addr_t;
  typedef enum logic [3:0] {
    IDLE, LOAD, LAST_WR, START, WAIT_LOW, WAIT_HIGH, RD_ADDR, RD_DATA, EMIT
  } host_state_t;
endpackage

// File: rtl/bitcoin_job_host.sv
// bitcoin_job_host: loads a header job into shared memory, runs the hash core, streams back H0 per nonce and the minimum
module bitcoin_job_host
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCES = NUM_NONCES_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int IDX_W = $clog2(NUM_NONCES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [15:0]      msg_base,
  input  logic [15:0]      out_base,
  input  logic             job_valid,
  input  logic [31:0]      job_data,
  output logic             job_ready,
  output logic             core_start,
  input  logic             core_done,
  output logic [15:0]      core_message_addr,
  output logic [15:0]      core_output_addr,
  output logic             mem_owner,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data,
  output logic             res_valid,
  output logic [31:0]      res_data,
  output logic [IDX_W-1:0] res_index,
  input  logic             res_ready,
  output logic             best_valid,
  output logic [31:0]      best_hash,
  output logic [IDX_W-1:0] best_nonce,
  output logic             busy
);
  localparam int WC_W = $clog2(NUM_WORDS);
  host_state_t state, state_n;
  logic [WC_W-1:0] wcnt;
  logic accept, xfer, last_j;
  assign accept = job_valid && job_ready;
  assign xfer = res_valid && res_ready;
  assign last_j = res_index == IDX_W'(NUM_NONCES - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = accept ? LOAD : IDLE;
      LOAD:      state_n = (accept && wcnt == WC_W'(NUM_WORDS - 2)) ? LAST_WR : LOAD;
      LAST_WR:   state_n = START;
      START:     state_n = WAIT_LOW;
      WAIT_LOW:  state_n = core_done ? WAIT_LOW : WAIT_HIGH;
      WAIT_HIGH: state_n = core_done ? RD_ADDR : WAIT_HIGH;
      RD_ADDR:   state_n = RD_DATA;
      RD_DATA:   state_n = EMIT;
      EMIT:      state_n = xfer ? (last_j ? IDLE : RD_ADDR) : EMIT;
      default:   state_n = IDLE;
    endcase
  end
  always_comb begin
    job_ready = state == IDLE || state == LOAD;
    core_start = state == START;
    mem_owner = !(state inside {START, WAIT_LOW, WAIT_HIGH});
    res_valid = state == EMIT;
    busy = state != IDLE;
  end
  // The port address is registered, so it is loaded on the edge that enters each write or RD_ADDR cycle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_write_data <= '0;
      wcnt <= '0;
      core_message_addr <= '0;
      core_output_addr <= '0;
      res_index <= '0;
      res_data <= '0;
      best_valid <= 1'b0;
    end else begin
      mem_we <= accept;
      if (accept) begin
        mem_addr <= state == IDLE ? msg_base : core_message_addr + addr_t'(wcnt);
        mem_write_data <= job_data;
        wcnt <= state == IDLE ? WC_W'(1) : wcnt + WC_W'(1);
      end
      if (accept && state == IDLE) begin
        core_message_addr <= msg_base;
        core_output_addr <= out_base;
        best_valid <= 1'b0;
      end
      if (state == WAIT_HIGH && core_done) begin
        res_index <= '0;
        mem_addr <= core_output_addr;
      end
      if (state == RD_DATA) res_data <= mem_read_data;
      if (state == EMIT && xfer) begin
        if (last_j) best_valid <= 1'b1;
        else begin
          res_index <= res_index + IDX_W'(1);
          mem_addr <= core_output_addr + addr_t'(res_index) + 16'd1;
        end
      end
    end
  // Strict compare keeps the earlier index on ties
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      best_hash <= '0;
      best_nonce <= '0;
    end else if (state == RD_DATA && (res_index == '0 || mem_read_data < best_hash)) begin
      best_hash <= mem_read_data;
      best_nonce <= res_index;
    end
endmodule

// File: tb/tb_bitcoin_job_host.sv
// tb_bitcoin_job_host: scoreboard bench with memory mux, core model and directed jobs
module tb_bitcoin_job_host;
  import bitcoin_pkg::*;
  logic clk, reset_n;
  logic [15:0] msg_base, out_base, core_message_addr, core_output_addr, mem_addr;
  logic job_valid, job_ready, core_start, core_done, mem_owner, mem_we;
  logic res_valid, res_ready, best_valid, busy;
  logic [31:0] job_data, mem_write_data, mem_read_data, res_data, best_hash;
  logic [3:0] res_index, best_nonce;
  logic core_we;
  logic [15:0] core_addr, port_addr;
  logic [31:0] core_wdata, port_wdata;
  logic port_we;
  logic [31:0] mem [0:65535];
  word_t res_mem [16];
  logic [47:0] wq[$];
  logic [35:0] rq[$];
  int tests = 0, fails = 0, cyc = 0, exp_starts = 0, start_cnt = 0;
  int last_acc = 0, done_rise = 0, last_xfer = 0;
  logic acc_prev = 0, prev_rv = 0, stall_prev = 0, prev_done = 0, stall_seen = 0;
  logic [51:0] snap = '0;

  bitcoin_job_host dut (
    .clk(clk), .reset_n(reset_n), .msg_base(msg_base), .out_base(out_base),
    .job_valid(job_valid), .job_data(job_data), .job_ready(job_ready),
    .core_start(core_start), .core_done(core_done),
    .core_message_addr(core_message_addr), .core_output_addr(core_output_addr),
    .mem_owner(mem_owner), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .res_valid(res_valid), .res_data(res_data), .res_index(res_index), .res_ready(res_ready),
    .best_valid(best_valid), .best_hash(best_hash), .best_nonce(best_nonce), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Top-level memory mux and synchronous-read memory
  assign port_we = mem_owner ? mem_we : core_we;
  assign port_addr = mem_owner ? mem_addr : core_addr;
  assign port_wdata = mem_owner ? mem_write_data : core_wdata;
  always @(posedge clk) begin
    if (port_we) mem[port_addr] <= port_wdata;
    mem_read_data <= mem[port_addr];
  end

  // Core model: done drops one cycle after start, results written, done rises 50 cycles later
  initial begin
    core_done = 1; core_we = 0; core_addr = 0; core_wdata = 0;
    forever begin
      @(posedge clk); #1;
      if (core_start) begin
        @(posedge clk); #1 core_done = 0;
        for (int i = 0; i < 16; i++) begin
          @(posedge clk); #1;
          core_we = 1; core_addr = core_output_addr + addr_t'(i); core_wdata = res_mem[i];
        end
        @(posedge clk); #1 core_we = 0;
        repeat (33) @(posedge clk);
        #1 core_done = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (core_done && !prev_done) done_rise <= cyc;
    prev_done <= core_done;
    if (reset_n) begin
      if (acc_prev || mem_we) chk("wr_timing", mem_we, acc_prev);
      if (mem_we) begin
        chk("wr_pending", wq.size() != 0, 1);
        if (wq.size() != 0) chk("wr_addr_data", {mem_addr, mem_write_data}, wq.pop_front());
      end
      if (job_valid && job_ready) last_acc <= cyc;
      acc_prev <= job_valid && job_ready;
      if (core_start) begin
        chk("start_gap", cyc - last_acc, 2);
        start_cnt <= start_cnt + 1;
      end
      if (stall_prev) chk("res_hold", {res_valid, res_data, res_index, mem_addr}, {1'b1, snap});
      if (res_valid) begin
        if (!prev_rv && res_index == 0) chk("done_to_valid", cyc - done_rise, 3);
        if (res_ready) begin
          chk("res_pending", rq.size() != 0, 1);
          if (rq.size() != 0) chk("res_data_index", {res_index, res_data}, rq.pop_front());
          if (res_index != 0 && !stall_seen) chk("res_spacing", cyc - last_xfer, 3);
          last_xfer <= cyc;
          stall_seen <= 0;
        end else stall_seen <= 1;
      end
      stall_prev <= res_valid && !res_ready;
      snap <= {res_data, res_index, mem_addr};
      prev_rv <= res_valid;
    end else begin
      acc_prev <= 0;
      stall_prev <= 0;
      prev_rv <= 0;
    end
  end

  task automatic chk_reset(input string nm);
    chk(nm, {job_ready, core_start, mem_owner, mem_we, mem_addr, mem_write_data, res_valid, res_data,
             res_index, best_valid, best_hash, best_nonce, busy, core_message_addr, core_output_addr},
        {1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 16'h0, 16'h0});
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk); #3 reset_n = 0;
    #1 chk_reset(nm);
    wq.delete();
    rq.delete();
    @(posedge clk); #1 reset_n = 1;
  endtask

  task automatic load_job(input addr_t mb, input addr_t ob, input bit tog, input int nw);
    int i = 0, n = 0;
    bit first = 1;
    msg_base = mb; out_base = ob;
    for (int k = 0; k < nw; k++) wq.push_back({addr_t'(mb + addr_t'(k)), word_t'(k)});
    if (nw == 19) exp_starts++;
    while (i < nw && n < 500) begin
      @(posedge clk); #1 n++;
      if (i == 1 && first) begin
        first = 0;
        chk("best_clear", best_valid, 0);
        msg_base = 16'hDEAD; out_base = 16'hBEEF;
      end
      job_valid = !(tog && cyc[0]); job_data = word_t'(i);
      if (job_valid && job_ready) i++;
    end
    @(posedge clk); #1 job_valid = 0;
    chk("load_timeout", n < 500, 1);
    chk("bases", {core_message_addr, core_output_addr}, {mb, ob});
  endtask

  task automatic finish_job(input int st, input word_t eb, input logic [3:0] en);
    int n = 0, sc = 0;
    for (int k = 0; k < 16; k++) rq.push_back({4'(k), res_mem[k]});
    while (!best_valid && n < 3000) begin
      @(posedge clk); #1 n++;
      res_ready = !(res_valid && int'(res_index) == st && sc < 10);
      if (!res_ready) sc++;
    end
    res_ready = 1;
    chk("job_timeout", n < 3000, 1);
    chk("best", {best_valid, busy, best_hash, best_nonce}, {1'b1, 1'b0, eb, en});
    chk("res_all_seen", rq.size(), 0);
    chk("start_count", start_cnt, exp_starts);
  endtask

  initial begin
    int n, bad;
    reset_n = 0; job_valid = 0; job_data = 0; msg_base = 0; out_base = 0; res_ready = 1;
    repeat (2) @(posedge clk);
    #1 chk_reset("reset_state");
    reset_n = 1;
    // Minimum at index 9
    for (int i = 0; i < 16; i++) res_mem[i] = 32'h10 + i;
    res_mem[9] = 32'h5;
    load_job(16'h0100, 16'h0200, 0, 19);
    finish_job(-1, 32'h5, 4'd9);
    // Toggled valid, tied minima at 3 and 12, stall on index 4
    for (int i = 0; i < 16; i++) res_mem[i] = 32'h100 + i;
    res_mem[3] = 32'h7; res_mem[12] = 32'h7;
    load_job(16'h0100, 16'h0200, 1, 19);
    finish_job(4, 32'h7, 4'd3);
    bad = 0;
    for (int i = 0; i < 19; i++) if (mem[16'h0100 + i] !== i) bad++;
    chk("mem_image", bad, 0);
    // Reset while waiting for the core
    load_job(16'h0100, 16'h0200, 0, 19);
    n = 0;
    while (core_done && n < 100) begin @(posedge clk); #1 n++; end
    chk("done_low_wait", core_done, 0);
    repeat (5) @(posedge clk);
    #1 chk("owner_in_wait", {mem_owner, busy}, 2'b01);
    do_reset("reset_wait_high");
    n = 0;
    while (!core_done && n < 200) begin @(posedge clk); #1 n++; end
    chk("done_high_wait", core_done, 1);
    // Reset in the middle of loading
    load_job(16'h0100, 16'h0200, 0, 7);
    do_reset("reset_mid_load");
    // Wrapping bases and an unsigned minimum
    for (int i = 0; i < 16; i++) res_mem[i] = 32'h8000_0000 + i;
    res_mem[2] = 32'h7FFF_FFFF;
    load_job(16'hFFF0, 16'hFFF8, 0, 19);
    finish_job(-1, 32'h7FFF_FFFF, 4'd2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bitcoin_job_host.md
# bitcoin_job_host

Host-side driver for the bitcoin_hash core: the other end of its memory and start/done interface. Accepts a 19-word block-header job as a valid/ready stream, writes it into the shared word memory, starts the core, waits for completion, then reads back one H0 word per nonce and streams the results out. While reading back, it tracks the minimum hash and its nonce index. It sits between the system job source and the hash core, and owns the shared memory port except while the core is running.

## Interface
- NUM_NONCES, 16, nonces computed per job; results read back
- NUM_WORDS, 20, header words; loader writes NUM_WORDS-1 (nonce slot is filled by the core)
- IDX_W, $clog2(NUM_NONCES), width of nonce index outputs

- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- msg_base  in  16  memory base address for the message; latched on the first accepted job word
- out_base  in  16  memory base address for the results; latched with msg_base
- job_valid  in  1  job word valid
- job_data  in  32  job word
- job_ready  out  1  loader accepts a word
- core_start  out  1  one-cycle start pulse to the core
- core_done  in  1  core done; level, high while the core is idle
- core_message_addr  out  16  latched msg_base
- core_output_addr  out  16  latched out_base
- mem_owner  out  1  1 = this block drives memory; 0 = core drives memory (top-level mux select)
- mem_we  out  1  write enable
- mem_addr  out  16  word address
- mem_write_data  out  32  write data
- mem_read_data  in  32  read data; valid one cycle after the address is presented
- res_valid  out  1  result word valid
- res_data  out  32  H0 for nonce res_index
- res_index  out  IDX_W  nonce index
- res_ready  in  1  result consumer ready
- best_valid  out  1  high after the last result transfer, until the next job starts
- best_hash  out  32  minimum H0 for the job
- best_nonce  out  IDX_W  index of the minimum H0
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, LAST_WR, START, WAIT_LOW, WAIT_HIGH, RD_ADDR, RD_DATA, EMIT.
- IDLE:
  - job_ready=1.
  - On an accepted word: latch the bases, clear best_valid, write word 0, go to LOAD.
- LOAD:
  - job_ready=1.
  - Word i is written to msg_base+i.
  - After word NUM_WORDS-2 is accepted, go to LAST_WR; job_ready drops the same edge.
- LAST_WR: the final write is on the port; next state START.
- START: core_start=1 for exactly this one cycle; mem_owner=0 from here through WAIT_HIGH.
- WAIT_LOW: wait for core_done==0.
- WAIT_HIGH: wait for core_done==1; then set index j=0 and go to RD_ADDR.
- RD_ADDR: mem_addr=out_base+j, mem_we=0.
- RD_DATA: capture mem_read_data into res_data and update the best values:
  - replace if j==0 or data < best_hash (unsigned compare);
  - on a tie, keep the lower index.
- EMIT:
  - res_valid=1, held stable until res_ready.
  - On transfer, if j==NUM_NONCES-1: set best_valid=1 and go to IDLE.
  - Otherwise j+1 and go to RD_ADDR.
- Address arithmetic is 16-bit modulo; base+offset wraps at 0xFFFF→0x0000.
- job_valid is ignored outside IDLE/LOAD.
- core_done is ignored outside the WAIT states.

## Timing
- Reset values: state IDLE; all outputs 0, except mem_owner=1 and job_ready=1.
- Reset mid-job aborts immediately; memory contents are left as written.
- mem_we, mem_addr and mem_write_data are registered: a word accepted at edge k is on the port during cycle k+1, with mem_we=1 for that cycle only.
- Back-to-back accepted words produce back-to-back writes.
- The final write occurs in the LAST_WR cycle; core_start asserts the next cycle.
- Readback takes 3 cycles per result when res_ready is held high. From core_done rising to the first res_valid is 3 cycles.
- best_valid rises the cycle after the final EMIT transfer, together with the return to IDLE.

## Structure
- Shared package bitcoin_pkg holds:
  - the host state enum;
  - NUM_NONCES_DEF=16 and NUM_WORDS_DEF=20;
  - typedef word_t (logic [31:0]) and addr_t (logic [15:0]).
- A single module, with no sub-module; the min-tracker is a small always_ff inside.
- The top level muxes the memory port using mem_owner.

## Test plan
- Load words 0x0000_0000..0x0000_0012 with msg_base=0x0100 and job_valid always high → 19 consecutive writes to 0x0100..0x0112; core_start pulses once, 2 cycles after the last acceptance.
- Same job with job_valid toggled every other cycle → identical memory image; no duplicate or skipped addresses.
- Core model drops core_done 1 cycle after start and raises it after 50 cycles; memory at out_base=0x0200 holds 0x10..0x1F except index 9 = 0x0000_0005 → 16 results in index order, best_hash=0x5, best_nonce=9.
- Results contain two equal minima at indices 3 and 12 → best_nonce=3.
- res_ready low for 10 cycles on index 4 → res_data and res_index are held; no memory read is issued until the transfer.
- Assert reset_n in WAIT_HIGH and again mid-LOAD → all outputs return to reset values asynchronously; a fresh job then completes normally.
